// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared state encoding and March C- element table for the BIST sequencer.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ELEM = 6;
    localparam int FAIL_COUNT_WIDTH = 16;

    // *_one selects ~BACKGROUND; a single-op element only uses the op0 fields.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_one;
        logic op1_wr;
        logic op1_one;
    } march_elem_t;

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b1, op1_one: 1'b1};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_one: 1'b1, op1_wr: 1'b1, op1_one: 1'b0};
            default: e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_one: 1'b0, op1_wr: 1'b0, op1_one: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// rtl/mbist_cmp_pipe.sv - two-stage expected-data delay line, comparator and first-fail capture.
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        push_valid,
    input  logic [DATA_WIDTH-1:0]       push_exp,
    input  logic [ADDR_WIDTH-1:0]       push_addr,
    input  logic [2:0]                  push_elem,
    input  logic [DATA_WIDTH-1:0]       rdata,
    output logic [FAIL_COUNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]       fail_addr,
    output logic [2:0]                  fail_elem,
    output logic [DATA_WIDTH-1:0]       fail_exp,
    output logic [DATA_WIDTH-1:0]       fail_obs
);

    localparam logic [FAIL_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic                        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]       s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
    logic [ADDR_WIDTH-1:0]       s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [2:0]                  s1_elem_q, s1_elem_d, s2_elem_q, s2_elem_d;
    logic [FAIL_COUNT_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0]       faddr_q, faddr_d;
    logic [2:0]                  felem_q, felem_d;
    logic [DATA_WIDTH-1:0]       fexp_q, fexp_d, fobs_q, fobs_d;
    logic                        mismatch;

    always_comb begin
        s1_valid_d = push_valid;
        s1_exp_d   = push_exp;
        s1_addr_d  = push_addr;
        s1_elem_d  = push_elem;
        s2_valid_d = s1_valid_q;
        s2_exp_d   = s1_exp_q;
        s2_addr_d  = s1_addr_q;
        s2_elem_d  = s1_elem_q;
        count_d    = count_q;
        faddr_d    = faddr_q;
        felem_d    = felem_q;
        fexp_d     = fexp_q;
        fobs_d     = fobs_q;
        mismatch   = s2_valid_q && (rdata != s2_exp_q);

        if (mismatch) begin
            if (count_q == '0) begin
                faddr_d = s2_addr_q;
                felem_d = s2_elem_q;
                fexp_d  = s2_exp_q;
                fobs_d  = rdata;
            end
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end

        if (clear) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            count_d    = '0;
            faddr_d    = '0;
            felem_d    = '0;
            fexp_d     = '0;
            fobs_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_addr_q  <= '0;
            s1_elem_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_addr_q  <= '0;
            s2_elem_q  <= '0;
            count_q    <= '0;
            faddr_q    <= '0;
            felem_q    <= '0;
            fexp_q     <= '0;
            fobs_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_exp_q   <= s1_exp_d;
            s1_addr_q  <= s1_addr_d;
            s1_elem_q  <= s1_elem_d;
            s2_valid_q <= s2_valid_d;
            s2_exp_q   <= s2_exp_d;
            s2_addr_q  <= s2_addr_d;
            s2_elem_q  <= s2_elem_d;
            count_q    <= count_d;
            faddr_q    <= faddr_d;
            felem_q    <= felem_d;
            fexp_q     <= fexp_d;
            fobs_q     <= fobs_d;
        end
    end

    assign fail_count = count_q;
    assign fail_addr  = faddr_q;
    assign fail_elem  = felem_q;
    assign fail_exp   = fexp_q;
    assign fail_obs   = fobs_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- sequencer: FSM, element/op/address counters, wdata look-ahead.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    CAPACITY   = 255,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_obs,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = BACKGROUND;
    localparam logic [DATA_WIDTH-1:0] ONE_DATA  = ~BACKGROUND;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [2:0]            LAST_ELEM = 3'(NUM_ELEM - 1);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  exh_q, exh_d;
    logic                  drain_q, drain_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic [2:0]            cmp_elem_q, cmp_elem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    march_elem_t           cur_e, nx_e;
    logic                  cur_wr, cur_one, nx_wr, nx_one;
    logic [2:0]            nx_elem;
    logic                  nx_op;
    logic [ADDR_WIDTH-1:0] nx_addr;
    logic                  nx_exh;
    logic                  accept, issue;

    // The counters always hold the op to be issued next, so wdata can be loaded from their successor.
    always_comb begin
        cur_e   = march_elem(elem_q);
        cur_wr  = op_q ? cur_e.op1_wr  : cur_e.op0_wr;
        cur_one = op_q ? cur_e.op1_one : cur_e.op0_one;
        nx_elem = elem_q;
        nx_op   = op_q;
        nx_addr = addr_q;
        nx_exh  = 1'b0;
        if (cur_e.two_ops && !op_q) begin
            nx_op = 1'b1;
        end else begin
            nx_op = 1'b0;
            if (cur_e.down ? (addr_q == '0) : (addr_q == LAST_ADDR)) begin
                if (elem_q == LAST_ELEM) begin
                    nx_elem = '0;
                    nx_addr = '0;
                    nx_exh  = 1'b1;
                end else begin
                    nx_elem = elem_q + 3'd1;
                    nx_addr = march_elem(elem_q + 3'd1).down ? LAST_ADDR : '0;
                end
            end else begin
                nx_addr = cur_e.down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            end
        end
        nx_e   = march_elem(nx_elem);
        nx_wr  = nx_op ? nx_e.op1_wr  : nx_e.op0_wr;
        nx_one = nx_op ? nx_e.op1_one : nx_e.op0_one;
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        exh_d       = exh_q;
        drain_d     = drain_q;
        wr_d        = wr_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        cmp_valid_d = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_elem_d  = cmp_elem_q;
        accept      = 1'b0;
        issue       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    issue   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exh_q) begin
                    state_d = DRAIN;
                    exh_d   = 1'b0;
                    drain_d = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                wr_d = 1'b0;
                if (drain_q) begin
                    state_d = DONE;
                    wdata_d = BACKGROUND;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            wr_d        = cur_wr;
            address_d   = addr_q;
            cmp_valid_d = !cur_wr;
            cmp_exp_d   = cur_one ? ONE_DATA : ZERO_DATA;
            cmp_elem_d  = elem_q;
            elem_d      = nx_elem;
            op_d        = nx_op;
            addr_d      = nx_addr;
            exh_d       = nx_exh;
            if (nx_wr) begin
                wdata_d = nx_one ? ONE_DATA : ZERO_DATA;
            end
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            exh_q       <= 1'b0;
            drain_q     <= 1'b0;
            wr_q        <= 1'b0;
            address_q   <= '0;
            wdata_q     <= BACKGROUND;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_elem_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            exh_q       <= exh_d;
            drain_q     <= drain_d;
            wr_q        <= wr_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_elem_q  <= cmp_elem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The issued read's fields form the head of the delay line; rdata lines up two stages later.
    mbist_cmp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .push_valid (cmp_valid_q),
        .push_exp   (cmp_exp_q),
        .push_addr  (address_q),
        .push_elem  (cmp_elem_q),
        .rdata      (mem_rdata),
        .fail_count (fail_count),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_exp   (fail_exp),
        .fail_obs   (fail_obs)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (fail_count == '0);
    assign mem_write_read = wr_q;
    assign mem_address    = address_q;
    assign mem_wdata      = wdata_q;

endmodule
